// File: rtl/lfsr_rr_scheduler_if.sv
// rtl/lfsr_rr_scheduler_if.sv - request/grant and random-word bundle between consumers and the scheduler
interface lfsr_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic               seed_load;
  logic [15:0]        seed;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               rnd_valid;
  logic [15:0]        rnd_data;
  logic               busy;

  modport master (
    output seed_load, seed, req,
    input  gnt, rnd_valid, rnd_data, busy
  );

  modport slave (
    input  seed_load, seed, req,
    output gnt, rnd_valid, rnd_data, busy
  );
endinterface

// File: rtl/lfsr_rr_scheduler.sv
// rtl/lfsr_rr_scheduler.sv - round-robin burst scheduler sharing one 16-bit Galois LFSR
module lfsr_rr_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter int          BURST_LEN   = 4,
  parameter logic [15:0] RESET_STATE = 16'hACE1
) (
  input logic                 clk,
  input logic                 reset,
  lfsr_rr_scheduler_if.slave  bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [PW-1:0]      rr_ptr;
  logic [BW-1:0]      beat_cnt;
  logic [NUM_REQ-1:0] gnt_q;

  logic [PW-1:0]      winner;
  logic               found;
  int                 idx;
  logic               owner_req;
  logic               last_beat;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Scan from the highest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req[idx]) begin
        winner = PW'(idx);
        found  = 1'b1;
      end
    end
  end

  // rr_ptr doubles as the burst owner once a grant is issued.
  assign owner_req = bus.req[rr_ptr];
  assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));

  assign bus.rnd_valid = (state == BURST) && owner_req && !bus.seed_load;
  assign bus.rnd_data  = lfsr;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state == BURST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lfsr     <= RESET_STATE;
      rr_ptr   <= PW'(NUM_REQ - 1);
      beat_cnt <= '0;
      gnt_q    <= '0;
    end else if (bus.seed_load) begin
      lfsr     <= (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
      state    <= IDLE;
      gnt_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            rr_ptr   <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (owner_req) begin
            lfsr <= lfsr_step(lfsr);
            if (last_beat) begin
              state    <= IDLE;
              gnt_q    <= '0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else begin
            state    <= IDLE;
            gnt_q    <= '0;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          gnt_q    <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// tb/tb_lfsr_rr_scheduler.sv - scoreboard bench for lfsr_rr_scheduler
module tb_lfsr_rr_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;

  lfsr_rr_scheduler_if #(.NUM_REQ(4)) bus ();

  lfsr_rr_scheduler #(
    .NUM_REQ(4), .BURST_LEN(4), .RESET_STATE(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_gnt[$];
  logic [15:0] exp_word[$];
  logic [15:0] model;
  logic [3:0] prev_gnt = 4'b0;
  int n;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    step = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int who, input int words);
    exp_gnt.push_back(who);
    for (int i = 0; i < words; i++) begin
      exp_word.push_back(model);
      model = step(model);
    end
  endtask

  task automatic wait_drain(input int max, output int cnt);
    cnt = 0;
    while ((exp_gnt.size() != 0 || exp_word.size() != 0) && cnt < max) begin
      tick();
      cnt++;
    end
    check_eq("drain", exp_gnt.size() + exp_word.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_gnt", {28'b0, bus.gnt}, 0);
    check_eq("rst_valid", {31'b0, bus.rnd_valid}, 0);
    check_eq("rst_busy", {31'b0, bus.busy}, 0);
    check_eq("rst_data", {16'b0, bus.rnd_data}, 32'hACE1);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_gnt = 4'b0;
    end else begin
      check_eq("busy_vs_gnt", {31'b0, bus.busy}, {31'b0, (bus.gnt != 4'b0)});
      if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
        if (exp_gnt.size() == 0) check_eq("gnt_extra", {28'b0, bus.gnt}, 0);
        else check_eq("gnt", {28'b0, bus.gnt}, 32'(1) << exp_gnt.pop_front());
      end
      if (bus.rnd_valid) begin
        if (exp_word.size() == 0) check_eq("word_extra", {16'b0, bus.rnd_data}, 0);
        else check_eq("word", {16'b0, bus.rnd_data}, {16'b0, exp_word.pop_front()});
      end
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    bus.seed_load = 1'b0;
    bus.seed = 16'h0;
    bus.req = 4'b0;
    #1;
    do_reset();

    // seed 1, single requester, two back-to-back bursts
    bus.seed_load = 1'b1; bus.seed = 16'h0001;
    tick();
    bus.seed_load = 1'b0;
    model = 16'h0001;
    push_burst(0, 4);
    push_burst(0, 4);
    bus.req = 4'b0001;
    wait_drain(40, n);
    check_eq("s1_cycles", n, 10);
    bus.req = 4'b0;

    // all requesters, rotating grants
    do_reset();
    model = 16'hACE1;
    push_burst(0, 4); push_burst(1, 4); push_burst(2, 4); push_burst(3, 4); push_burst(0, 4);
    bus.req = 4'b1111;
    wait_drain(100, n);
    check_eq("s2_cycles", n, 25);
    bus.req = 4'b0;

    // requester 2 withdraws after two words, requester 3 next
    tick();
    push_burst(2, 2);
    bus.req = 4'b1100;
    wait_drain(20, n);
    bus.req = 4'b1000;
    push_burst(3, 4);
    wait_drain(20, n);
    check_eq("s3_cycles", n, 6);
    bus.req = 4'b0;

    // zero seed mid-burst aborts; rr_ptr kept
    tick();
    push_burst(1, 2);
    bus.req = 4'b0010;
    wait_drain(20, n);
    bus.seed_load = 1'b1; bus.seed = 16'h0000; bus.req = 4'b0111;
    tick();
    bus.seed_load = 1'b0;
    check_eq("s4_gnt", {28'b0, bus.gnt}, 0);
    check_eq("s4_busy", {31'b0, bus.busy}, 0);
    check_eq("s4_lfsr", {16'b0, bus.rnd_data}, 32'h0001);
    model = 16'h0001;
    push_burst(2, 4);
    wait_drain(20, n);
    check_eq("s4_cycles", n, 5);
    bus.req = 4'b0;

    // seed load and request in the same idle cycle
    tick();
    bus.seed_load = 1'b1; bus.seed = 16'h1234; bus.req = 4'b0010;
    tick();
    bus.seed_load = 1'b0;
    check_eq("s5_nognt", {28'b0, bus.gnt}, 0);
    check_eq("s5_lfsr", {16'b0, bus.rnd_data}, 32'h1234);
    model = 16'h1234;
    push_burst(1, 4);
    tick();
    check_eq("s5_gnt", {28'b0, bus.gnt}, 32'h2);
    wait_drain(20, n);
    bus.req = 4'b0;

    // asynchronous reset mid-burst
    tick();
    push_burst(2, 1);
    bus.req = 4'b0100;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_gnt", {28'b0, bus.gnt}, 0);
    check_eq("ar_valid", {31'b0, bus.rnd_valid}, 0);
    check_eq("ar_busy", {31'b0, bus.busy}, 0);
    check_eq("ar_data", {16'b0, bus.rnd_data}, 32'hACE1);
    check_eq("ar_queue", exp_gnt.size() + exp_word.size(), 0);
    bus.req = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
    model = 16'hACE1;
    push_burst(0, 4);
    wait_drain(20, n);
    bus.req = 4'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
